// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store master for DATA_MEMORY with registered read data.
// Optional byte-lane stores (read-modify-write) are enabled by defining LSU_BYTE_WRITE_EN.
module load_store_unit #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [ADDRESS_WIDTH-1:0]  req_address,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   req_byte_sel,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [DATA_WIDTH-1:0]     resp_rdata,
   output logic [ADDRESS_WIDTH-1:0]  mem_write_address,
   output logic                      mem_write_enable,
   output logic [DATA_WIDTH-1:0]     mem_data_write,
   output logic [ADDRESS_WIDTH-1:0]  mem_read_address,
   output logic                      mem_read_enable,
   input  logic [DATA_WIDTH-1:0]     mem_data_read
);

   localparam int LANES = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WRITE      = 3'd1,
      ST_RD_ISSUE   = 3'd2,
      ST_RD_CAPTURE = 3'd3,
      ST_RESP       = 3'd4
`ifdef LSU_BYTE_WRITE_EN
      ,
      ST_RMW_ISSUE   = 3'd5,
      ST_RMW_CAPTURE = 3'd6,
      ST_RMW_WRITE   = 3'd7
`endif
   } state_t;

   state_t                     state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic                       accept_s;

   logic                       req_ready_q, req_ready_d;
   logic                       resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0]      resp_rdata_q, resp_rdata_d;
   logic [ADDRESS_WIDTH-1:0]   mem_write_address_q, mem_write_address_d;
   logic                       mem_write_enable_q, mem_write_enable_d;
   logic [DATA_WIDTH-1:0]      mem_data_write_q, mem_data_write_d;
   logic [ADDRESS_WIDTH-1:0]   mem_read_address_q, mem_read_address_d;
   logic                       mem_read_enable_q, mem_read_enable_d;

`ifdef LSU_BYTE_WRITE_EN
   logic [LANES-1:0]           bsel_q, bsel_d;

   // Old word with the selected byte lanes replaced by the new word.
   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [LANES-1:0]      sel
   );
      logic [DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int b = 0; b < LANES; b++) begin
         if (sel[b]) begin
            merged[8*b +: 8] = new_word[8*b +: 8];
         end else begin
            merged[8*b +: 8] = old_word[8*b +: 8];
         end
      end
      return merged;
   endfunction
`else
   logic unused_byte_sel_s;
   assign unused_byte_sel_s = ^req_byte_sel;
`endif

   assign accept_s = req_valid & req_ready_q;

   // State register, request latches and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q             <= ST_IDLE;
         addr_q              <= {ADDRESS_WIDTH{1'b0}};
         wdata_q             <= {DATA_WIDTH{1'b0}};
         req_ready_q         <= 1'b0;
         resp_valid_q        <= 1'b0;
         resp_rdata_q        <= {DATA_WIDTH{1'b0}};
         mem_write_address_q <= {ADDRESS_WIDTH{1'b0}};
         mem_write_enable_q  <= 1'b0;
         mem_data_write_q    <= {DATA_WIDTH{1'b0}};
         mem_read_address_q  <= {ADDRESS_WIDTH{1'b0}};
         mem_read_enable_q   <= 1'b0;
`ifdef LSU_BYTE_WRITE_EN
         bsel_q              <= {LANES{1'b0}};
`endif
      end else begin
         state_q             <= state_d;
         addr_q              <= addr_d;
         wdata_q             <= wdata_d;
         req_ready_q         <= req_ready_d;
         resp_valid_q        <= resp_valid_d;
         resp_rdata_q        <= resp_rdata_d;
         mem_write_address_q <= mem_write_address_d;
         mem_write_enable_q  <= mem_write_enable_d;
         mem_data_write_q    <= mem_data_write_d;
         mem_read_address_q  <= mem_read_address_d;
         mem_read_enable_q   <= mem_read_enable_d;
`ifdef LSU_BYTE_WRITE_EN
         bsel_q              <= bsel_d;
`endif
      end
   end

   // Next-state logic and request capture at acceptance.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef LSU_BYTE_WRITE_EN
      bsel_d  = bsel_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               addr_d  = req_address;
               wdata_d = req_wdata;
`ifdef LSU_BYTE_WRITE_EN
               bsel_d  = req_byte_sel;
`endif
               if (!req_write) begin
                  state_d = ST_RD_ISSUE;
               end else begin
`ifdef LSU_BYTE_WRITE_EN
                  // Only a genuinely partial lane mask needs the old word.
                  if ((req_byte_sel == {LANES{1'b1}}) || (req_byte_sel == {LANES{1'b0}})) begin
                     state_d = ST_WRITE;
                  end else begin
                     state_d = ST_RMW_ISSUE;
                  end
`else
                  state_d = ST_WRITE;
`endif
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE:      state_d = ST_IDLE;
         ST_RD_ISSUE:   state_d = ST_RD_CAPTURE;
         ST_RD_CAPTURE: state_d = ST_RESP;
         ST_RESP: begin
            if (resp_valid_q && resp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
`ifdef LSU_BYTE_WRITE_EN
         ST_RMW_ISSUE:   state_d = ST_RMW_CAPTURE;
         ST_RMW_CAPTURE: state_d = ST_RMW_WRITE;
         ST_RMW_WRITE:   state_d = ST_IDLE;
`endif
         default:        state_d = ST_IDLE;
      endcase
   end

   // Output next values derived from the state being entered, so outputs align with it.
   always_comb begin
      req_ready_d         = (state_d == ST_IDLE);
      resp_valid_d        = (state_d == ST_RESP);
      resp_rdata_d        = resp_rdata_q;
      mem_write_address_d = mem_write_address_q;
      mem_write_enable_d  = 1'b0;
      mem_data_write_d    = mem_data_write_q;
      mem_read_address_d  = mem_read_address_q;
      mem_read_enable_d   = 1'b0;
      if (state_q == ST_RD_CAPTURE) begin
         resp_rdata_d = mem_data_read;
      end else begin
         resp_rdata_d = resp_rdata_q;
      end
      case (state_d)
         ST_WRITE: begin
            mem_write_address_d = addr_d;
            mem_data_write_d    = wdata_d;
`ifdef LSU_BYTE_WRITE_EN
            mem_write_enable_d  = (bsel_d != {LANES{1'b0}});
`else
            mem_write_enable_d  = 1'b1;
`endif
         end
         ST_RD_ISSUE: begin
            mem_read_address_d = addr_d;
            mem_read_enable_d  = 1'b1;
         end
`ifdef LSU_BYTE_WRITE_EN
         ST_RMW_ISSUE: begin
            mem_read_address_d = addr_d;
            mem_read_enable_d  = 1'b1;
         end
         ST_RMW_WRITE: begin
            mem_write_address_d = addr_q;
            mem_data_write_d    = merge_lanes(mem_data_read, wdata_q, bsel_q);
            mem_write_enable_d  = 1'b1;
         end
`endif
         default: begin
            mem_write_enable_d = 1'b0;
            mem_read_enable_d  = 1'b0;
         end
      endcase
   end

   assign req_ready         = req_ready_q;
   assign resp_valid        = resp_valid_q;
   assign resp_rdata        = resp_rdata_q;
   assign mem_write_address = mem_write_address_q;
   assign mem_write_enable  = mem_write_enable_q;
   assign mem_data_write    = mem_data_write_q;
   assign mem_read_address  = mem_read_address_q;
   assign mem_read_enable   = mem_read_enable_q;

endmodule
